// File: rtl/option22_write_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : option22_write_sched_if
// Purpose  : Requester handshake and buffer-drive bundle for the option22
//            write scheduler. The requester side is the master; the
//            scheduler is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface option22_write_sched_if #(
  parameter int WORD_COUNT = 32,
  parameter int ADDR_W     = $clog2(WORD_COUNT)
);
  // requester A
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [7:0]        data_a;
  logic              ack_a;
  // requester B
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        data_b;
  logic              ack_b;
  // buffer drive and status
  logic              buf_write;
  logic              buf_din;
  logic [ADDR_W-1:0] word_idx;
  logic              byte_strobe;
  logic              busy;

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    input  ack_a, ack_b,
    input  buf_write, buf_din, word_idx, byte_strobe, busy
  );

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    output ack_a, ack_b,
    output buf_write, buf_din, word_idx, byte_strobe, busy
  );
endinterface
`default_nettype wire

// File: rtl/option22_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : option22_write_sched
// Purpose  : Round-robin write scheduler for the option22 circular bit-serial
//            byte buffer. Accepts {addr,data} from two requesters, waits for
//            the addressed slot to rotate to the insertion point, then shifts
//            the byte out MSB first over exactly 8 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module option22_write_sched #(
  parameter int WORD_COUNT = 32
) (
  input  wire                   clk,
  input  wire                   reset,
  option22_write_sched_if.slave bus
);

  localparam int   ADDR_W = $clog2(WORD_COUNT);
  localparam logic RR_A   = 1'b0;
  localparam logic RR_B   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [2:0]        bit_cnt_q,  bit_cnt_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] tgt_q,      tgt_d;
  logic [7:0]        shreg_q,    shreg_d;
  logic              rr_ptr_q,   rr_ptr_d;

  logic              grant_a;
  logic              grant_b;
  logic              last_bit;
  logic [ADDR_W-1:0] next_word;

  // Last bit of the current byte period; the ring index wraps naturally
  // because WORD_COUNT is a power of two.
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign next_word = word_idx_q + ADDR_W'(1);

  // Next-state logic: free-running bit/slot counters plus the grant/wait/shift FSM.
  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    word_idx_d = last_bit ? next_word : word_idx_q;
    state_d    = state_q;
    tgt_d      = tgt_q;
    shreg_d    = shreg_q;
    rr_ptr_d   = rr_ptr_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A wins when alone or when the round-robin pointer favours it.
        if (bus.req_a && (!bus.req_b || (rr_ptr_q == RR_A))) begin
          grant_a = 1'b1;
        end else if (bus.req_b) begin
          grant_b = 1'b1;
        end

        if (grant_a) begin
          tgt_d    = bus.addr_a;
          shreg_d  = bus.data_a;
          rr_ptr_d = RR_B;
          state_d  = ST_WAIT;
        end else if (grant_b) begin
          tgt_d    = bus.addr_b;
          shreg_d  = bus.data_b;
          rr_ptr_d = RR_A;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Leave on the edge that opens the target slot's byte period. A grant
        // made on that very edge only reaches WAIT afterwards, so it waits a
        // full revolution.
        if (last_bit && (next_word == tgt_q)) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        if (last_bit) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset aligned to the buffer's reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      word_idx_q <= '0;
      tgt_q      <= '0;
      shreg_q    <= 8'd0;
      rr_ptr_q   <= RR_A;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      tgt_q      <= tgt_d;
      shreg_q    <= shreg_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Acks are suppressed during reset so a held request is dropped and must
  // be re-accepted once reset is released.
  assign bus.ack_a       = grant_a & ~reset;
  assign bus.ack_b       = grant_b & ~reset;
  assign bus.buf_write   = (state_q == ST_SHIFT);
  assign bus.buf_din     = (state_q == ST_SHIFT) & shreg_q[7];
  assign bus.word_idx    = word_idx_q;
  assign bus.byte_strobe = last_bit;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
